// File: rtl/dmx_pkg.sv
// Shared constants, word kinds and line-FSM states for the DMX512 transmit path.
package dmx_pkg;

  localparam logic [7:0]  DMX_STATUS_BREAK = 8'hbb;
  localparam logic [7:0]  DMX_STATUS_DATA  = 8'h00;
  localparam int unsigned DMX_MAX_SLOTS    = 512;
  localparam int unsigned SLOT_COUNT_W     = 10;

  typedef enum logic [1:0] {
    KIND_BREAK   = 2'd0,
    KIND_DATA    = 2'd1,
    KIND_DISCARD = 2'd2
  } wordKind_t;

  typedef struct packed {
    wordKind_t  kind;
    logic [7:0] data;
  } holdWord_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_BREAK    = 3'd1,
    S_MAB      = 3'd2,
    S_SLOT     = 3'd3,
    S_SLOTWAIT = 3'd4
  } txState_t;

  function automatic wordKind_t decodeStatus(input logic [7:0] status);
    if (status == DMX_STATUS_BREAK) return KIND_BREAK;
    if (status == DMX_STATUS_DATA)  return KIND_DATA;
    return KIND_DISCARD;
  endfunction

endpackage

// File: rtl/dmx_uart_tx.sv
// 8N2 serializer: start bit, 8 data bits LSB first, two stop bits; line idles at mark.
module dmx_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 48
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Start,
  input  logic [7:0] i_Byte,
  output logic       o_Serial,
  output logic       o_Busy,
  output logic       o_Done
);

  localparam int unsigned CLK_W      = $clog2(CLKS_PER_BIT);
  localparam int unsigned BITS_AFTER = 10;

  logic [CLK_W-1:0] clkCnt;
  logic [3:0]       bitsLeft;
  logic [9:0]       shiftReg;

  // Start bit goes out the cycle after i_Start; shiftReg holds data then stop bits.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_Serial <= 1'b1;
      o_Busy   <= 1'b0;
      o_Done   <= 1'b0;
      clkCnt   <= '0;
      bitsLeft <= '0;
      shiftReg <= '1;
    end else begin
      o_Done <= 1'b0;
      if (!o_Busy) begin
        if (i_Start) begin
          o_Busy   <= 1'b1;
          o_Serial <= 1'b0;
          shiftReg <= {2'b11, i_Byte};
          bitsLeft <= 4'(BITS_AFTER);
          clkCnt   <= '0;
        end
      end else if (clkCnt == CLK_W'(CLKS_PER_BIT - 1)) begin
        clkCnt <= '0;
        if (bitsLeft == 4'd0) begin
          o_Busy   <= 1'b0;
          o_Done   <= 1'b1;
          o_Serial <= 1'b1;
        end else begin
          o_Serial <= shiftReg[0];
          shiftReg <= {1'b1, shiftReg[9:1]};
          bitsLeft <= bitsLeft - 4'd1;
        end
      end else begin
        clkCnt <= clkCnt + CLK_W'(1);
      end
    end
  end

endmodule

// File: rtl/dmx_tx.sv
// DMX512 transmitter: parses host (status, data) byte pairs into a one-word hold
// register and plays BREAK, MAB, start code and data slots onto the line.
module dmx_tx
  import dmx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 48,
  parameter int unsigned BREAK_BITS   = 23,
  parameter int unsigned MAB_BITS     = 3
) (
  input  logic                    i_Clock,
  input  logic                    i_Reset_n,
  input  logic                    i_dataValid,
  input  logic [7:0]              i_data,
  output logic                    o_ready,
  output logic                    o_Tx_Serial,
  output logic                    o_Tx_Active,
  output logic                    o_error,
  output logic [SLOT_COUNT_W-1:0] o_slotCount
);

  localparam int unsigned BREAK_CYCLES = BREAK_BITS * CLKS_PER_BIT;
  localparam int unsigned MAB_CYCLES   = MAB_BITS * CLKS_PER_BIT;
  localparam int unsigned TIMER_W      =
    $clog2((BREAK_CYCLES > MAB_CYCLES) ? BREAK_CYCLES : MAB_CYCLES);

  logic      accept_c;
  logic      consume_c;
  logic      phaseData;
  wordKind_t statusKind;
  holdWord_t holdWord;

  txState_t                 state, stateNext;
  logic                     lineLevel, lineLevelNext;
  logic                     uartStart, uartStartNext;
  logic [7:0]               txByte, txByteNext;
  logic                     startCodeSlot, startCodeSlotNext;
  logic                     frameOpen, frameOpenNext;
  logic [TIMER_W-1:0]       timer, timerNext;
  logic                     errorNext;
  logic                     activeNext;
  logic [SLOT_COUNT_W-1:0]  slotCountNext;

  logic uartSerial;
  logic uartBusy;
  logic uartDone;

  assign accept_c = i_dataValid && o_ready;

  // Byte parser: o_ready doubles as "hold register empty".
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      phaseData     <= 1'b0;
      statusKind    <= KIND_DISCARD;
      holdWord.kind <= KIND_DISCARD;
      holdWord.data <= '0;
      o_ready       <= 1'b1;
    end else begin
      if (accept_c) begin
        phaseData <= !phaseData;
      end
      if (accept_c && !phaseData) begin
        statusKind <= decodeStatus(i_data);
      end
      if (accept_c && phaseData) begin
        holdWord.kind <= statusKind;
        holdWord.data <= i_data;
        o_ready       <= 1'b0;
      end else if (consume_c) begin
        o_ready <= 1'b1;
      end
    end
  end

  // Line FSM registers, including all registered outputs.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state         <= S_IDLE;
      lineLevel     <= 1'b1;
      uartStart     <= 1'b0;
      txByte        <= '0;
      startCodeSlot <= 1'b0;
      frameOpen     <= 1'b0;
      timer         <= '0;
      o_error       <= 1'b0;
      o_Tx_Active   <= 1'b0;
      o_slotCount   <= '0;
    end else begin
      state         <= stateNext;
      lineLevel     <= lineLevelNext;
      uartStart     <= uartStartNext;
      txByte        <= txByteNext;
      startCodeSlot <= startCodeSlotNext;
      frameOpen     <= frameOpenNext;
      timer         <= timerNext;
      o_error       <= errorNext;
      o_Tx_Active   <= activeNext;
      o_slotCount   <= slotCountNext;
    end
  end

  always_comb begin
    stateNext         = state;
    lineLevelNext     = 1'b1;
    uartStartNext     = 1'b0;
    txByteNext        = txByte;
    startCodeSlotNext = startCodeSlot;
    frameOpenNext     = frameOpen;
    timerNext         = timer;
    errorNext         = 1'b0;
    slotCountNext     = o_slotCount;
    consume_c         = 1'b0;
    case (state)
      S_IDLE: begin
        if (!o_ready) begin
          consume_c = 1'b1;
          case (holdWord.kind)
            KIND_BREAK: begin
              stateNext         = S_BREAK;
              lineLevelNext     = 1'b0;
              txByteNext        = holdWord.data;
              startCodeSlotNext = 1'b1;
              frameOpenNext     = 1'b1;
              slotCountNext     = '0;
              timerNext         = '0;
            end
            KIND_DATA: begin
              if (frameOpen && (o_slotCount < SLOT_COUNT_W'(DMX_MAX_SLOTS))) begin
                stateNext         = S_SLOT;
                uartStartNext     = 1'b1;
                txByteNext        = holdWord.data;
                startCodeSlotNext = 1'b0;
              end else begin
                errorNext = 1'b1;
              end
            end
            default: errorNext = 1'b1;
          endcase
        end
      end
      S_BREAK: begin
        if (timer == TIMER_W'(BREAK_CYCLES - 1)) begin
          stateNext = S_MAB;
          timerNext = '0;
        end else begin
          lineLevelNext = 1'b0;
          timerNext     = timer + TIMER_W'(1);
        end
      end
      // The S_SLOT cycle is still mark, so MAB ends one cycle early to keep it exact.
      S_MAB: begin
        if (timer == TIMER_W'(MAB_CYCLES - 2)) begin
          stateNext     = S_SLOT;
          uartStartNext = 1'b1;
        end else begin
          timerNext = timer + TIMER_W'(1);
        end
      end
      S_SLOT: stateNext = S_SLOTWAIT;
      S_SLOTWAIT: begin
        if (uartDone) begin
          stateNext = S_IDLE;
          if (!startCodeSlot && (o_slotCount < SLOT_COUNT_W'(DMX_MAX_SLOTS))) begin
            slotCountNext = o_slotCount + SLOT_COUNT_W'(1);
          end
        end
      end
      default: stateNext = S_IDLE;
    endcase
    activeNext = (stateNext != S_IDLE) || uartBusy;
  end

  dmx_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uUart (
    .i_Clock  (i_Clock),
    .i_Reset_n(i_Reset_n),
    .i_Start  (uartStart),
    .i_Byte   (txByte),
    .o_Serial (uartSerial),
    .o_Busy   (uartBusy),
    .o_Done   (uartDone)
  );

  // Both sources are flops that idle at mark, so reset forces the line high at once.
  assign o_Tx_Serial = lineLevel & uartSerial;

endmodule

// File: tb/tb_dmx_tx.sv
// Directed plus randomized bench for dmx_tx: full-rate instance for timing,
// fast-bit instance for the 512-slot saturation case.
module tb_dmx_tx;

  localparam int CPB       = 48;
  localparam int BREAK_CYC = 23 * CPB;
  localparam int MAB_CYC   = 3 * CPB;
  localparam int SLOT_CYC  = 11 * CPB;
  localparam int FAST_CPB  = 4;
  localparam int WAIT_MAX  = 5000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstN, dValid, dReady, dLine, dActive, dError;
  logic [7:0] dData;
  logic [9:0] dCount;
  logic       fRstN, fValid, fReady, fLine, fActive, fError;
  logic [7:0] fData;
  logic [9:0] fCount;

  int checks     = 0;
  int passed     = 0;
  int expCount   = 0;
  int fErrCount  = 0;
  int breakCount = 0;
  logic [7:0] decodedQ[$];
  logic [7:0] expQ[$];
  logic [7:0] decByte;
  logic       decOk;

  dmx_tx dut (
    .i_Clock(clk), .i_Reset_n(rstN), .i_dataValid(dValid), .i_data(dData),
    .o_ready(dReady), .o_Tx_Serial(dLine), .o_Tx_Active(dActive),
    .o_error(dError), .o_slotCount(dCount)
  );

  dmx_tx #(.CLKS_PER_BIT(FAST_CPB), .BREAK_BITS(23), .MAB_BITS(3)) dutFast (
    .i_Clock(clk), .i_Reset_n(fRstN), .i_dataValid(fValid), .i_data(fData),
    .o_ready(fReady), .o_Tx_Serial(fLine), .o_Tx_Active(fActive),
    .o_error(fError), .o_slotCount(fCount)
  );

  always @(posedge clk) if (fError === 1'b1) fErrCount <= fErrCount + 1;

  // UART receiver on the fast line; a frame with low stop bits is a BREAK.
  initial begin
    forever begin
      @(negedge clk);
      if (fRstN === 1'b1 && fLine === 1'b0) begin
        repeat (FAST_CPB / 2) @(negedge clk);
        decOk = (fLine === 1'b0);
        for (int j = 0; j < 8; j++) begin
          repeat (FAST_CPB) @(negedge clk);
          decByte[j] = fLine;
        end
        repeat (FAST_CPB) @(negedge clk);
        decOk = decOk & (fLine === 1'b1);
        repeat (FAST_CPB) @(negedge clk);
        decOk = decOk & (fLine === 1'b1);
        if (decOk) decodedQ.push_back(decByte);
        else begin
          breakCount++;
          while (fLine === 1'b0) @(negedge clk);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  // Expected line level i cycles into a slot carrying byte b.
  function automatic logic slotLevel(input logic [7:0] b, input int i, input int cpb);
    int bitIdx;
    bitIdx = i / cpb;
    if (bitIdx == 0) return 1'b0;
    if (bitIdx <= 8) return b[bitIdx-1];
    return 1'b1;
  endfunction

  task automatic sendByte(input bit fast, input logic [7:0] b);
    int w;
    @(negedge clk);
    if (fast) begin fValid = 1'b1; fData = b; end
    else      begin dValid = 1'b1; dData = b; end
    w = 0;
    while (!(fast ? fReady : dReady) && w < WAIT_MAX) begin
      @(negedge clk);
      w++;
    end
    if (w >= WAIT_MAX) chk("ready_timeout", w, 0);
    @(posedge clk);
    #1;
    if (fast) fValid = 1'b0;
    else      dValid = 1'b0;
  endtask

  task automatic waitLow(input int limit, output int k);
    logic found;
    k = 0;
    found = 1'b0;
    while (!found && k < limit) begin
      @(negedge clk);
      k++;
      found = (dLine === 1'b0);
    end
    if (!found) k = -1;
  endtask

  task automatic countRun(input logic level, input int limit, output int n);
    logic same;
    n = 1;
    same = 1'b1;
    while (same && n < limit) begin
      @(negedge clk);
      if (dLine === level) n++;
      else same = 1'b0;
    end
  endtask

  // Current sample is the first cycle of the start bit.
  task automatic checkSlotWave(input logic [7:0] b, input string tag);
    int mism;
    logic [7:0] dec;
    mism = (dLine !== 1'b0) ? 1 : 0;
    dec = '0;
    for (int i = 1; i < SLOT_CYC; i++) begin
      @(negedge clk);
      if (dLine !== slotLevel(b, i, CPB)) mism++;
      if ((i % CPB) == CPB / 2 && (i / CPB) >= 1 && (i / CPB) <= 8) dec[i/CPB-1] = dLine;
    end
    chk({tag, "_wave"}, mism, 0);
    chk({tag, "_byte"}, 32'(dec), 32'(b));
  endtask

  task automatic dataSlot(input logic [7:0] b, input string tag);
    int k;
    sendByte(1'b0, 8'h00);
    sendByte(1'b0, b);
    waitLow(10, k);
    chk({tag, "_latency"}, k, 3);
    checkSlotWave(b, tag);
    expCount++;
    repeat (2) @(negedge clk);
    chk({tag, "_count"}, 32'(dCount), expCount);
  endtask

  task automatic dropWord(input logic [7:0] st, input logic [7:0] dt, input string tag);
    int errAt, errCnt, lowCnt;
    sendByte(1'b0, st);
    sendByte(1'b0, dt);
    errAt = -1; errCnt = 0; lowCnt = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (dError === 1'b1) begin errCnt++; errAt = k; end
      if (dLine !== 1'b1) lowCnt++;
    end
    chk({tag, "_errcnt"}, errCnt, 1);
    chk({tag, "_errat"}, errAt, 2);
    chk({tag, "_line"}, lowCnt, 0);
    chk({tag, "_count"}, 32'(dCount), expCount);
  endtask

  task automatic breakFrame(input logic [7:0] sc, input string tag);
    int k, n;
    sendByte(1'b0, 8'hbb);
    sendByte(1'b0, sc);
    waitLow(10, k);
    chk({tag, "_latency"}, k, 2);
    chk({tag, "_active"}, 32'(dActive), 1);
    chk({tag, "_ready"}, 32'(dReady), 1);
    chk({tag, "_clear"}, 32'(dCount), 0);
    countRun(1'b0, BREAK_CYC + 50, n);
    chk({tag, "_breaklen"}, n, BREAK_CYC);
    countRun(1'b1, MAB_CYC + 50, n);
    chk({tag, "_mablen"}, n, MAB_CYC);
    checkSlotWave(sc, {tag, "_sc"});
    repeat (2) @(negedge clk);
    expCount = 0;
    chk({tag, "_sccount"}, 32'(dCount), 0);
  endtask

  initial begin
    int k, mism;
    logic [7:0] st, b;
    rstN = 1'b0; fRstN = 1'b0;
    dValid = 1'b0; dData = '0; fValid = 1'b0; fData = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_line", 32'(dLine), 1);
    chk("rst_ready", 32'(dReady), 1);
    chk("rst_active", 32'(dActive), 0);
    chk("rst_error", 32'(dError), 0);
    chk("rst_count", 32'(dCount), 0);
    @(negedge clk);
    rstN = 1'b1; fRstN = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_line", 32'(dLine), 1);

    // DATA before any BREAK is dropped
    dropWord(8'h00, 8'h12, "nobreak");

    // Unknown status dropped, then parser still aligned for a BREAK
    dropWord(8'h42, 8'h77, "discard42");
    breakFrame(8'h00, "brk1");
    dataSlot(8'h55, "slot55");

    // Randomized mix of data slots and discard words
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      if ($urandom_range(0, 2) == 0) begin
        st = 8'($urandom_range(1, 255));
        if (st == 8'hbb) st = 8'hbc;
        dropWord(st, 8'($urandom), "rnd_discard");
      end else begin
        dataSlot(8'($urandom), "rnd_slot");
      end
    end

    // New frame with random start code restarts the count
    breakFrame(8'($urandom), "brk2");
    dataSlot(8'($urandom), "slot_after_brk2");

    // Reset in the middle of BREAK
    sendByte(1'b0, 8'hbb);
    sendByte(1'b0, 8'h00);
    waitLow(10, k);
    chk("mid_rst_latency", k, 2);
    repeat (499) @(negedge clk);
    chk("mid_rst_prelow", 32'(dLine), 0);
    rstN = 1'b0;
    #1;
    chk("mid_rst_line", 32'(dLine), 1);
    chk("mid_rst_active", 32'(dActive), 0);
    chk("mid_rst_ready", 32'(dReady), 1);
    chk("mid_rst_count", 32'(dCount), 0);
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    expCount = 0;
    dropWord(8'h00, 8'h12, "closed_after_rst");

    // 513 DATA words into one frame on the fast instance
    expQ.push_back(8'h00);
    sendByte(1'b1, 8'hbb);
    sendByte(1'b1, 8'h00);
    for (int i = 0; i < 513; i++) begin
      b = 8'($urandom);
      if (i < 512) expQ.push_back(b);
      sendByte(1'b1, 8'h00);
      sendByte(1'b1, b);
    end
    repeat (300) @(negedge clk);
    chk("sat_count", 32'(fCount), 512);
    chk("sat_errors", fErrCount, 1);
    chk("sat_breaks", breakCount, 1);
    chk("sat_slots", decodedQ.size(), expQ.size());
    mism = 0;
    for (int i = 0; i < expQ.size() && i < decodedQ.size(); i++)
      if (decodedQ[i] !== expQ[i]) mism++;
    chk("sat_bytes", mism, 0);
    chk("sat_idle", 32'(fActive), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
